// File: rtl/serv_rf_pkg.sv
// Shared definitions for the register-file storage stage: fill-FSM states
// and sizing helpers used by the storage top and its fill sequencer.
package serv_rf_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  // Number of width-bit words backing all GPRs plus CSRs.
  function automatic int rf_depth(input int width, input int rf_count, input int csr_regs);
    return (rf_count + csr_regs) * 32 / width;
  endfunction

  // Number of words that make up register x0.
  function automatic int x0_words(input int width);
    return 32 / width;
  endfunction

endpackage

// File: rtl/serv_rf_clr_seq.sv
// Zero-fill sequencer: walks every word of the array after reset or on an
// i_clr request, holding the core off via o_busy until the walk completes.
module serv_rf_clr_seq
  import serv_rf_pkg::*;
#(
  parameter int depth = 128,
  parameter int aw    = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  output logic [aw-1:0] o_waddr,
  output logic          o_we,
  output logic          o_busy,
  output logic          o_done
);

  localparam int CW = aw + 1;
  localparam logic [CW-1:0] LAST = CW'(depth - 1);

  rf_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_done, w_done_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A clear request arriving mid-fill is ignored so the walk never restarts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_READY: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_waddr = r_cnt[aw-1:0];
  assign o_we    = (r_state == ST_CLEAR);
  assign o_busy  = (r_state == ST_CLEAR);
  assign o_done  = r_done;

endmodule

// File: rtl/serv_rf_ram_ctrl.sv
// Register-file/CSR storage array behind the bit-serial RF interface:
// 1-cycle read-first RAM, x0 read-as-zero, zero-fill after reset or on request.
module serv_rf_ram_ctrl
  import serv_rf_pkg::*;
#(
  parameter int width      = 8,
  parameter int csr_regs   = 0,
  parameter int rf_count   = 32,
  parameter int raw        = $clog2(rf_count + csr_regs),
  parameter int l2w        = $clog2(width),
  parameter int aw         = 5 + raw - l2w,
  parameter int depth      = rf_depth(width, rf_count, csr_regs),
  parameter int x0_protect = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  output logic             o_busy,
  output logic             o_done,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata
);

  localparam logic [aw:0] DEPTH_L = (aw + 1)'(depth);
  localparam logic [aw:0] X0W_L   = (aw + 1)'(x0_words(width));

  logic [width-1:0] r_mem [depth];
  logic [width-1:0] r_rdata;

  logic [aw-1:0]    w_clr_addr;
  logic             w_clr_we;
  logic             w_busy;
  logic             w_wr_ok, w_rd_ok;
  logic             w_we;
  logic [aw-1:0]    w_waddr;
  logic [width-1:0] w_wdata;

  serv_rf_clr_seq #(
    .depth (depth),
    .aw    (aw)
  ) u_clr_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .o_waddr (w_clr_addr),
    .o_we    (w_clr_we),
    .o_busy  (w_busy),
    .o_done  (o_done)
  );

  assign w_wr_ok = ({1'b0, i_waddr} < DEPTH_L) &&
                   !((x0_protect != 0) && ({1'b0, i_waddr} < X0W_L));
  // x0 is forced to read zero even if a write path to it exists.
  assign w_rd_ok = ({1'b0, i_raddr} < DEPTH_L) && ({1'b0, i_raddr} >= X0W_L);

  // The fill sequencer owns the write port for the whole walk.
  assign w_we    = w_clr_we | (!w_busy && i_wen && w_wr_ok);
  assign w_waddr = w_clr_we ? w_clr_addr : i_waddr;
  assign w_wdata = w_clr_we ? '0 : i_wdata;

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rdata <= '0;
    else if (!w_busy && i_ren)
      r_rdata <= w_rd_ok ? r_mem[i_raddr] : '0;
  end

  assign o_busy  = w_busy;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_serv_rf_ram_ctrl.sv
// Randomised self-checking bench for serv_rf_ram_ctrl (default parameters)
// against a plain array model of the storage.
module tb_serv_rf_ram_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_clr = 1'b0;
  logic       o_busy, o_done;
  logic [6:0] i_waddr = '0;
  logic [7:0] i_wdata = '0;
  logic       i_wen = 1'b0;
  logic [6:0] i_raddr = '0;
  logic       i_ren = 1'b0;
  logic [7:0] o_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [128];
  logic [7:0] exp_rd;
  logic       m_busy;

  serv_rf_ram_ctrl dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_wen   (i_wen),
    .i_raddr (i_raddr),
    .i_ren   (i_ren),
    .o_rdata (o_rdata)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] mdl_read(input logic [6:0] a);
    return (a < 7'd4) ? 8'h00 : mem_m[a];
  endfunction

  task automatic mdl_wipe();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
  endtask

  // One clock of stimulus; model updated read-first, outputs sampled 1ns after the edge.
  task automatic cyc(input logic wen, input logic [6:0] wa, input logic [7:0] wd,
                     input logic ren, input logic [6:0] ra, input logic clr);
    i_wen = wen; i_waddr = wa; i_wdata = wd;
    i_ren = ren; i_raddr = ra; i_clr = clr;
    @(posedge i_clk);
    if (!m_busy) begin
      if (ren) exp_rd = mdl_read(ra);
      if (wen && wa >= 7'd4) mem_m[wa] = wd;
      if (clr) begin
        m_busy = 1'b1;
        mdl_wipe();
      end
    end
    #1;
    i_wen = 1'b0; i_ren = 1'b0; i_clr = 1'b0;
  endtask

  task automatic wait_fill(output int n, output int dn);
    n = 0; dn = 0;
    while (o_busy === 1'b1 && n < 400) begin
      cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n++;
      if (o_done === 1'b1) dn++;
    end
    m_busy = 1'b0;
  endtask

  task automatic test_reset();
    int n, dn;
    m_busy = 1'b1; exp_rd = 8'h00;
    mdl_wipe();
    #1;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", o_rdata); end
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    wait_fill(n, dn);
    total++; if (n != 128) begin bad++; $display("FAIL fill_len got=%0d exp=128", n); end
    total++; if (dn != 1) begin bad++; $display("FAIL fill_done_pulses got=%0d exp=1", dn); end
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", o_done); end
    for (int a = 0; a < 128; a++) begin
      cyc(1'b0, '0, '0, 1'b1, 7'(a), 1'b0);
      total++;
      if (o_rdata !== exp_rd) begin bad++; $display("FAIL zero_read a=%0d got=%h exp=%h", a, o_rdata, exp_rd); end
    end
  endtask

  task automatic test_write_read();
    cyc(1'b1, 7'h25, 8'hA5, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 7'h25, 1'b0);
    total++; if (o_rdata !== 8'hA5) begin bad++; $display("FAIL wr_rd got=%h exp=a5", o_rdata); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 7'h10, 1'b0);
      total++; if (o_rdata !== 8'hA5) begin bad++; $display("FAIL rd_hold got=%h exp=a5", o_rdata); end
    end
  endtask

  task automatic test_same_cycle();
    cyc(1'b1, 7'h25, 8'h5A, 1'b1, 7'h25, 1'b0);
    total++; if (o_rdata !== 8'hA5) begin bad++; $display("FAIL rd_first got=%h exp=a5", o_rdata); end
    cyc(1'b0, '0, '0, 1'b1, 7'h25, 1'b0);
    total++; if (o_rdata !== 8'h5A) begin bad++; $display("FAIL rd_after_wr got=%h exp=5a", o_rdata); end
  endtask

  task automatic test_x0();
    for (int a = 0; a < 5; a++) cyc(1'b1, 7'(a), 8'hFF, 1'b0, '0, 1'b0);
    for (int a = 0; a < 5; a++) begin
      cyc(1'b0, '0, '0, 1'b1, 7'(a), 1'b0);
      total++;
      if (o_rdata !== ((a == 4) ? 8'hFF : 8'h00)) begin
        bad++; $display("FAIL x0_protect a=%0d got=%h exp=%h", a, o_rdata, (a == 4) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), 7'($urandom), 8'($urandom), 1'($urandom), 7'($urandom_range(0, 15)), 1'b0);
      total++;
      if (o_rdata !== exp_rd) begin bad++; $display("FAIL rand_rw it=%0d got=%h exp=%h", i, o_rdata, exp_rd); end
    end
  endtask

  task automatic test_clr();
    int n, dn;
    logic [7:0] hold;
    cyc(1'b1, 7'h10, 8'h33, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 7'h10, 1'b0);
    total++; if (o_rdata !== 8'h33) begin bad++; $display("FAIL pre_clr got=%h exp=33", o_rdata); end
    hold = exp_rd;
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL clr_busy got=%b exp=1", o_busy); end
    n = 0; dn = 0;
    while (o_busy === 1'b1 && n < 400) begin
      cyc(1'b1, 7'h10, 8'hEE, 1'b1, 7'h10, (n == 40));
      n++;
      if (o_done === 1'b1) dn++;
      if (o_busy === 1'b1 && o_rdata !== hold) begin
        total++; bad++; $display("FAIL clr_rd_hold n=%0d got=%h exp=%h", n, o_rdata, hold);
      end
    end
    m_busy = 1'b0;
    total++; if (n != 128) begin bad++; $display("FAIL clr_len got=%0d exp=128", n); end
    total++; if (dn != 1) begin bad++; $display("FAIL clr_done got=%0d exp=1", dn); end
    cyc(1'b0, '0, '0, 1'b1, 7'h10, 1'b0);
    total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL clr_zero got=%h exp=00", o_rdata); end
  endtask

  task automatic test_reset_mid();
    int n, dn;
    cyc(1'b1, 7'h30, 8'h77, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 7'h30, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 50; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    exp_rd = 8'h00; m_busy = 1'b1; mdl_wipe();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_rst_busy got=%b exp=1", o_busy); end
    total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL mid_rst_rdata got=%h exp=00", o_rdata); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    wait_fill(n, dn);
    total++; if (n != 128) begin bad++; $display("FAIL mid_rst_len got=%0d exp=128", n); end
    total++; if (dn != 1) begin bad++; $display("FAIL mid_rst_done got=%0d exp=1", dn); end
    cyc(1'b0, '0, '0, 1'b1, 7'h30, 1'b0);
    total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL mid_rst_zero got=%h exp=00", o_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_x0();
    test_random();
    test_clr();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
